// File: rtl/core_pkg.sv
// Shared core package: scoreboard entry type and small register helpers.
package core_pkg;

  // One scoreboard slot: a pending register write between issue and writeback.
  typedef struct packed {
    logic         valid;
    rv::regaddr_t rd;
  } core_sb_entry_t;

  // x0 is hardwired to zero, so it is never tracked and never a dependency.
  function automatic logic is_x0(input rv::regaddr_t r);
    return r == rv::X0;
  endfunction

endpackage

// File: rtl/rv.sv
// Base RISC-V types shared across the core: register address and the x0 constant.
package rv;

  typedef logic [4:0] regaddr_t;

  localparam regaddr_t X0 = 5'd0;

endpackage

// File: rtl/core_scoreboard.sv
// Circular FIFO of in-flight destination registers with two parallel lookup ports.
module core_scoreboard
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  rv::regaddr_t     push_rd,
  input  logic             pop,
  input  rv::regaddr_t     pop_rd,
  input  rv::regaddr_t     look1_rd,
  input  rv::regaddr_t     look2_rd,
  output logic [DEPTH-1:0] match1,
  output logic [DEPTH-1:0] match2,
  output logic             full,
  output logic             err_empty_pop,
  output logic             err_rd_mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  core_sb_entry_t     entries_reg [DEPTH];
  logic [AW-1:0]      head_reg;
  logic [AW-1:0]      head_next;
  logic [AW-1:0]      tail_reg;
  logic [AW-1:0]      tail_next;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic               empty;
  logic               do_push;
  logic               do_pop;
  logic [DEPTH-1:0]   wr_sel;
  logic [DEPTH-1:0]   clr_sel;
  rv::regaddr_t       head_rd;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);

  // Full can never see a push because decode stalls on full; the guard keeps
  // the FIFO consistent even if a caller misbehaves.
  assign do_push = push & ~full;
  // Pops on an empty FIFO are dropped and reported.
  assign do_pop  = pop & ~empty;

  assign head_rd         = entries_reg[head_reg].rd;
  assign err_empty_pop   = pop & empty;
  assign err_rd_mismatch = do_pop & (head_rd != pop_rd);

  // Per-slot write/clear decode and the two lookup match vectors.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign wr_sel[gi]  = do_push & (tail_reg == AW'(gi));
      assign clr_sel[gi] = do_pop  & (head_reg == AW'(gi));
      assign match1[gi]  = entries_reg[gi].valid & (entries_reg[gi].rd == look1_rd);
      assign match2[gi]  = entries_reg[gi].valid & (entries_reg[gi].rd == look2_rd);
    end
  endgenerate

  // Pointer and occupancy next-state; simultaneous push/pop leaves count unchanged.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (do_push) begin
      tail_next = tail_reg + AW'(1);
    end
    if (do_pop) begin
      head_next = head_reg + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Slot storage; push and pop never target the same slot in one cycle
  // because that would require the FIFO to be both full and empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          entries_reg[i].valid <= 1'b1;
          entries_reg[i].rd    <= push_rd;
        end else if (clr_sel[i]) begin
          entries_reg[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/core_hazard_ctrl.sv
// Decode stall/flush generation from the register scoreboard, plus stall counter.
module core_hazard_ctrl
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  rv::regaddr_t     d_rs1,
  input  logic             d_want_rs1,
  input  rv::regaddr_t     d_rs2,
  input  logic             d_want_rs2,
  input  rv::regaddr_t     d_rd,
  input  logic             d_reg_wen,
  input  logic             x_ready,
  input  logic             x_redirect,
  input  logic             wb_valid,
  input  rv::regaddr_t     wb_rd,
  input  logic             wb_reg_wen,
  output logic             d_stall,
  output logic             d_flush,
  output logic             sb_full,
  output logic             sb_err,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic             haz1;
  logic             haz2;
  logic             issue;
  logic             push;
  logic             pop;
  logic             err_empty_pop;
  logic             err_rd_mismatch;
  logic             sb_err_reg;
  logic [CNT_W-1:0] stall_cycles_reg;

  // Writes are retired into the register file at the edge, with no bypass, so
  // the lookup only sees registered scoreboard state: a retiring register still
  // stalls in its retire cycle.
  core_scoreboard #(
    .DEPTH(DEPTH)
  ) u_sb (
    .clk             (clk),
    .rst             (rst),
    .push            (push),
    .push_rd         (d_rd),
    .pop             (pop),
    .pop_rd          (wb_rd),
    .look1_rd        (d_rs1),
    .look2_rd        (d_rs2),
    .match1          (match1),
    .match2          (match2),
    .full            (sb_full),
    .err_empty_pop   (err_empty_pop),
    .err_rd_mismatch (err_rd_mismatch)
  );

  assign haz1    = d_want_rs1 & ~is_x0(d_rs1) & (|match1);
  assign haz2    = d_want_rs2 & ~is_x0(d_rs2) & (|match2);

  assign d_flush = x_redirect;
  assign d_stall = d_valid & (haz1 | haz2 | sb_full);

  // A redirect squashes decode, so nothing is issued or tracked that cycle.
  assign issue   = d_valid & ~d_stall & ~d_flush & x_ready;
  assign push    = issue & d_reg_wen & ~is_x0(d_rd);
  assign pop     = wb_valid & wb_reg_wen & ~is_x0(wb_rd);

  assign sb_err       = sb_err_reg;
  assign stall_cycles = stall_cycles_reg;

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_reg <= 1'b0;
    end else if (err_empty_pop | err_rd_mismatch) begin
      sb_err_reg <= 1'b1;
    end
  end

  // Saturating count of cycles where a valid decode instruction is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
    end else if (d_valid & d_stall & ~(&stall_cycles_reg)) begin
      stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed bench for core_hazard_ctrl: stimulus queues expectations, a monitor checks them.
module tb_core_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             d_valid;
  logic [4:0]       d_rs1;
  logic             d_want_rs1;
  logic [4:0]       d_rs2;
  logic             d_want_rs2;
  logic [4:0]       d_rd;
  logic             d_reg_wen;
  logic             x_ready;
  logic             x_redirect;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             wb_reg_wen;
  logic             d_stall;
  logic             d_flush;
  logic             sb_full;
  logic             sb_err;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct {
    string            name;
    logic             stall;
    logic             flush;
    logic             full;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  core_hazard_ctrl #(.DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_valid      (d_valid),
    .d_rs1        (d_rs1),
    .d_want_rs1   (d_want_rs1),
    .d_rs2        (d_rs2),
    .d_want_rs2   (d_want_rs2),
    .d_rd         (d_rd),
    .d_reg_wen    (d_reg_wen),
    .x_ready      (x_ready),
    .x_redirect   (x_redirect),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_reg_wen   (wb_reg_wen),
    .d_stall      (d_stall),
    .d_flush      (d_flush),
    .sb_full      (sb_full),
    .sb_err       (sb_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input string fld, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s got=%0b want=%0b", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk1(e.name, "d_stall", d_stall, e.stall);
      chk1(e.name, "d_flush", d_flush, e.flush);
      chk1(e.name, "sb_full", sb_full, e.full);
      chk1(e.name, "sb_err",  sb_err,  e.err);
      checks++;
      if (stall_cycles !== e.cnt) begin
        failures++;
        $display("FAIL %s.stall_cycles got=%0d want=%0d", e.name, stall_cycles, e.cnt);
      end
      $display("txn %-12s stall=%0b flush=%0b full=%0b err=%0b cnt=%0d",
               e.name, d_stall, d_flush, sb_full, sb_err, stall_cycles);
    end
  end

  // One cycle of stimulus with its hand-computed expected outputs.
  task automatic step(input string nm,
                      input int dv, input int rs1, input int w1, input int rs2, input int w2,
                      input int rd, input int wen, input int xr, input int rdr,
                      input int wbv, input int wbrd,
                      input int es, input int ef, input int efull, input int eerr, input int ecnt);
    exp_t e;
    d_valid    = dv[0];
    d_rs1      = rs1[4:0];
    d_want_rs1 = w1[0];
    d_rs2      = rs2[4:0];
    d_want_rs2 = w2[0];
    d_rd       = rd[4:0];
    d_reg_wen  = wen[0];
    x_ready    = xr[0];
    x_redirect = rdr[0];
    wb_valid   = wbv[0];
    wb_rd      = wbrd[4:0];
    wb_reg_wen = wbv[0];
    e.name  = nm;
    e.stall = es[0];
    e.flush = ef[0];
    e.full  = efull[0];
    e.err   = eerr[0];
    e.cnt   = 32'(ecnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_valid = 0; d_rs1 = 0; d_want_rs1 = 0; d_rs2 = 0; d_want_rs2 = 0;
    d_rd = 0; d_reg_wen = 0; x_ready = 0; x_redirect = 0;
    wb_valid = 0; wb_rd = 0; wb_reg_wen = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    //    name          dv rs1 w1 rs2 w2 rd wen xr rdr wbv wbrd  stall flush full err cnt
    step("reset",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // back-to-back RAW on x5
    step("raw_prod",    1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    step("raw_st1",     1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0);
    step("raw_st2",     1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1);
    step("raw_wb",      1, 5, 1, 0, 0, 6, 1, 1, 0, 1, 5,   1, 0, 0, 0, 2);
    step("raw_go",      1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0,   0, 0, 0, 0, 3);
    step("raw_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);
    step("raw_ret6",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6,   0, 0, 0, 0, 3);
    // x0 and want masking
    step("x0_prod",     1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 3);
    step("prod7",       1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,   0, 0, 0, 0, 3);
    step("nowant",      1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);
    step("want7",       1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 3);
    step("ret7",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 0, 0, 4);
    // fill the scoreboard
    step("fill1",       1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 4);
    step("fill2",       1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0,   0, 0, 0, 0, 4);
    step("fill3",       1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0,   0, 0, 0, 0, 4);
    step("fill4",       1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0,   0, 0, 0, 0, 4);
    step("full_st",     1,10, 1, 0, 0, 8, 1, 1, 0, 0, 0,   1, 0, 1, 0, 4);
    step("full_ret1",   1,10, 1, 0, 0, 8, 1, 1, 0, 1, 1,   1, 0, 1, 0, 5);
    step("full_go",     1,10, 1, 0, 0, 8, 1, 1, 0, 0, 0,   0, 0, 0, 0, 6);
    step("drain2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2,   0, 0, 1, 0, 6);
    step("drain3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0, 0, 6);
    step("drain4",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,   0, 0, 0, 0, 6);
    step("drain8",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8,   0, 0, 0, 0, 6);
    // simultaneous push/pop at count 2, wrapping the pointers
    step("pp_pre11",    1, 0, 0, 0, 0,11, 1, 1, 0, 0, 0,   0, 0, 0, 0, 6);
    step("pp_pre12",    1, 0, 0, 0, 0,12, 1, 1, 0, 0, 0,   0, 0, 0, 0, 6);
    for (int k = 0; k < 6; k++) begin
      step($sformatf("pp_%0d", k), 1, 0, 0, 0, 0, 13 + k, 1, 1, 0, 1, 11 + k,
           0, 0, 0, 0, 6);
    end
    step("pp_has17",    1,17, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 6);
    step("pp_no16",     1,16, 1,18, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 7);
    step("pp_has18",    1, 0, 0,18, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 7);
    step("pp_ret17",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1,17,   0, 0, 0, 0, 8);
    step("pp_ret18",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1,18,   0, 0, 0, 0, 8);
    // redirect handling
    step("rd_prod20",   1, 0, 0, 0, 0,20, 1, 1, 0, 0, 0,   0, 0, 0, 0, 8);
    step("rd_stall",    1,20, 1, 0, 0,21, 1, 1, 0, 0, 0,   1, 0, 0, 0, 8);
    step("rd_flushst",  1,20, 1, 0, 0,21, 1, 1, 1, 0, 0,   1, 1, 0, 0, 9);
    step("rd_flush22",  1, 0, 0, 0, 0,22, 1, 1, 1, 0, 0,   0, 1, 0, 0,10);
    step("rd_no22",     1,22, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,10);
    step("rd_keep20",   1,20, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0,10);
    step("rd_ret20",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1,20,   0, 0, 0, 0,11);
    // protocol error: retire x9 while head holds x3
    step("err_prod3",   1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0,   0, 0, 0, 0,11);
    step("err_bad9",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 0, 0, 0,11);
    step("err_sticky",  1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1,11);
    step("err_prod9",   1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0,   0, 0, 0, 1,11);

    // mid-operation reset discards the pending x9 and clears error/counter
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_clear",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    step("rst_no9",     1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    step("empty_pop",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 0, 0, 0, 0);
    step("empty_err",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);

    idle_inputs();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
